switch_debounce_4: RTL and testbench

Input-conditioning stage that sits directly upstream of the lab's four-input combinational logic blocks (inputs A, B, C, D). It synchronizes four asynchronous board switch/button signals into the clock domain and debounces each one independently. It then presents stable levels to the downstream logic, together with a one-cycle change strobe and a per-bit change mask. The downstream logic and any event counters consume these outputs directly.

---
 rtl/switch_debounce_4.sv | 59 +++++
 tb/tb_switch_debounce_4.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_4.sv
// Four-channel switch conditioner: two-flop synchronizer plus an independent
// debounce counter per bit, with a registered change strobe and change mask.
module switch_debounce_4 #(
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_in,
    output logic [3:0] sw_out,
    output logic       changed,
    output logic [3:0] chg_mask
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [3:0] s1_reg;
    logic [3:0] s2_reg;
    logic [3:0] flip_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : bit_g
            logic [CNT_W-1:0] cnt_reg;
            logic             differ;

            assign differ        = s2_reg[gi] ^ sw_out[gi];
            // The output follows only after DB_CYCLES consecutive disagreeing edges.
            assign flip_next[gi] = differ && (cnt_reg == CNT_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (!differ || flip_next[gi]) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            sw_out   <= '0;
            changed  <= 1'b0;
            chg_mask <= '0;
        end else begin
            s1_reg   <= sw_in;
            s2_reg   <= s1_reg;
            sw_out   <= sw_out ^ flip_next;
            changed  <= |flip_next;
            chg_mask <= flip_next;
        end
    end

endmodule

// File: tb/tb_switch_debounce_4.sv
// Scoreboard bench for switch_debounce_4: stimulus pushes expected per-edge
// outputs from a window-based reference model; a monitor pops and compares.
module tb_switch_debounce_4;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_in = 4'b0000;
    logic [3:0] sw_out;
    logic       changed;
    logic [3:0] chg_mask;

    int n_vec = 0;
    int n_bad = 0;

    switch_debounce_4 #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_in    (sw_in),
        .sw_out   (sw_out),
        .changed  (changed),
        .chg_mask (chg_mask)
    );

    always #5 clk = ~clk;

    // Reference model: captured input history since reset, indexed by edge-1.
    // The value seen by the debounce stage at edge j is the one captured at j-2.
    // A bit flips at edge k when every value seen over the last DB edges
    // disagrees with its output and it has not flipped within the last DB-1 edges.
    logic [3:0] hist_q[$];
    logic [8:0] exp_q[$];
    int         last_flip[4];
    logic [3:0] m_out;
    int         edge_n;

    task automatic model_reset();
        hist_q.delete();
        exp_q.delete();
        m_out  = 4'b0000;
        edge_n = 0;
        for (int b = 0; b < 4; b++) last_flip[b] = -1000;
    endtask

    task automatic model_step(input logic [3:0] v);
        logic [3:0] flips;
        logic [3:0] seen;
        bit         ok;
        edge_n++;
        hist_q.push_back(v);
        flips = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            ok = (edge_n - last_flip[b]) >= DB;
            for (int j = edge_n - DB + 1; j <= edge_n; j++) begin
                seen = (j - 2 >= 1) ? hist_q[j-3] : 4'b0000;
                if (seen[b] == m_out[b]) ok = 1'b0;
            end
            if (ok) begin
                flips[b]     = 1'b1;
                last_flip[b] = edge_n;
            end
        end
        m_out = m_out ^ flips;
        exp_q.push_back({m_out, |flips, flips});
    endtask

    task automatic cyc(input logic [3:0] v);
        @(negedge clk);
        sw_in = v;
        model_step(v);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge with v applied.
    task automatic mid_reset(input logic [3:0] v);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({sw_out, changed, chg_mask} !== 9'd0) begin
            n_bad++;
            $display("FAIL async_reset: got out=%b chg=%b mask=%b, want all zero",
                     sw_out, changed, chg_mask);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sw_in = v;
        model_step(v);
    endtask

    // Monitor: one comparison per post-reset rising edge.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_underflow: no expected entry at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("edge out=%b chg=%b mask=%b exp out=%b chg=%b mask=%b",
                             sw_out, changed, chg_mask, e[8:5], e[4], e[3:0]);
                    if ({sw_out, changed, chg_mask} !== e) begin
                        n_bad++;
                        $display("FAIL outputs: got out=%b chg=%b mask=%b, want out=%b chg=%b mask=%b",
                                 sw_out, changed, chg_mask, e[8:5], e[4], e[3:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] v;
        model_reset();
        rst_n = 1'b0;
        sw_in = 4'b0000;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({sw_out, changed, chg_mask} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_state: got out=%b chg=%b mask=%b, want all zero",
                     sw_out, changed, chg_mask);
        end
        rst_n = 1'b1;
        model_step(4'b0000);

        // Idle, single-bit rise, glitch rejection and minimum qualifying pulse.
        repeat (20) cyc(4'b0000);
        repeat (10) cyc(4'b0100);
        repeat (3)  cyc(4'b0101);
        repeat (10) cyc(4'b0100);
        repeat (4)  cyc(4'b0101);
        repeat (10) cyc(4'b0100);

        // Multi-bit simultaneous qualification, then a single bit returning.
        repeat (10) cyc(4'b0000);
        repeat (10) cyc(4'b1011);
        repeat (10) cyc(4'b0011);

        // Bounce on bit1 settling high.
        repeat (10) cyc(4'b0000);
        cyc(4'b0010); cyc(4'b0000); cyc(4'b0010); cyc(4'b0000);
        repeat (10) cyc(4'b0010);

        // Reset while bit3 is pending, then recovery with bit3 held high.
        repeat (6) cyc(4'b0000);
        repeat (3) cyc(4'b1000);
        mid_reset(4'b1000);
        repeat (5) cyc(4'b1000);
        n_vec++;
        if (sw_out[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_edge5: got sw_out[3]=%b, want 0", sw_out[3]);
        end
        cyc(4'b1000);
        n_vec++;
        if (sw_out[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_edge6: got sw_out[3]=%b, want 1", sw_out[3]);
        end
        repeat (5) cyc(4'b1000);

        // Randomized per-bit toggling with short and long runs, plus resets.
        v = 4'b1000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            if (n % 700 == 699) mid_reset(v);
            else                cyc(v);
        end

        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
